// File: rtl/keccak_share_arb_pkg.sv
// Shared types and helpers for the Keccak core-sharing arbiter.
package keccak_share_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned WDOG_W  = 12;
  localparam int unsigned RCNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RSTK = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  // Round-robin pick on a MAX_REQ-wide vector of which the low n bits are live;
  // returns ptr when nothing is requesting.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   ptr,
                                                input int unsigned        n);
    logic             found;
    int unsigned      idx;
    logic [IDX_W-1:0] pick;
    found = 1'b0;
    pick  = ptr;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (!found && k < n && req[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick_n.sv
// Combinational round-robin picker: rotate by ptr, find lowest set bit, rotate back.
module rr_pick_n #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  localparam int unsigned SW = IW + 1;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [SW-1:0]  sum;

  // Rotate so ptr lands at bit 0, priority-encode, then map back to a requester index
  always_comb begin
    dbl   = {req, req};
    rot   = N'(dbl >> ptr);
    off   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = IW'(i);
        valid = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= SW'(N)) sum = sum - SW'(N);
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/keccak_share_arb.sv
// Time-shares one Keccak core among N_REQ requesters, one whole job per grant.
module keccak_share_arb
  import keccak_share_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned W        = 64,
  parameter int unsigned RST_CYC  = 2,
  parameter int unsigned MAX_BUSY = 4095
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  output logic [N_REQ-1:0]   gnt,
  input  logic [N_REQ*W-1:0] r_din,
  input  logic [N_REQ-1:0]   r_src_ready,
  output logic [N_REQ-1:0]   r_src_read,
  output logic [N_REQ*W-1:0] r_dout,
  output logic [N_REQ-1:0]   r_dst_write,
  input  logic [N_REQ-1:0]   r_dst_ready,
  output logic               k_rst,
  output logic [W-1:0]       k_din,
  output logic               k_src_ready,
  input  logic               k_src_read,
  input  logic [W-1:0]       k_dout,
  input  logic               k_dst_write,
  output logic               k_dst_ready,
  output logic               busy,
  output logic               wdog_err
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       g_q, g_d;
  logic [IW-1:0]       g_next;
  logic [N_REQ-1:0]    gnt_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic                abort_q, abort_d;
  logic [WDOG_W-1:0]   wcnt_q, wcnt_d;
  logic                wdog_d;
  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  logic                own_req;

  rr_pick_n #(.N(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign own_req = req[g_q];
  assign g_next  = (g_q == IW'(N_REQ - 1)) ? '0 : g_q + 1'b1;

  // State, pointer, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      g_q      <= '0;
      gnt      <= '0;
      rcnt_q   <= '0;
      abort_q  <= 1'b0;
      wcnt_q   <= '0;
      wdog_err <= 1'b0;
      k_rst    <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      g_q      <= g_d;
      gnt      <= gnt_d;
      rcnt_q   <= rcnt_d;
      abort_q  <= abort_d;
      wcnt_q   <= wcnt_d;
      wdog_err <= wdog_d;
      k_rst    <= (state_d == ST_RSTK);
      busy     <= (state_d != ST_IDLE);
    end
  end

  // Next-state: arbitrate in IDLE, time the core reset pulse, release on req fall
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    gnt_d   = gnt;
    rcnt_d  = rcnt_q;
    abort_d = abort_q;
    wcnt_d  = wcnt_q;
    wdog_d  = wdog_err;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_RSTK;
          g_d     = pick_idx;
          gnt_d   = N_REQ'(1) << pick_idx;
          rcnt_d  = '0;
          abort_d = 1'b0;
        end
      end
      ST_RSTK: begin
        // A drop anywhere in the pulse aborts, but the pulse always completes
        abort_d = abort_q | ~own_req;
        if (rcnt_q == RCNT_W'(RST_CYC - 1)) begin
          if (abort_q || !own_req) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            ptr_d   = g_next;
          end else begin
            state_d = ST_BUSY;
            wcnt_d  = '0;
          end
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      ST_BUSY: begin
        if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
        if (MAX_BUSY != 0 && wcnt_d == WDOG_W'(MAX_BUSY)) wdog_d = 1'b1;
        if (!own_req) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = g_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake routing between the owner and the core, open only in BUSY
  always_comb begin
    k_din       = '0;
    k_src_ready = 1'b0;
    k_dst_ready = 1'b0;
    r_src_read  = '0;
    r_dst_write = '0;
    if (state_q == ST_BUSY) begin
      k_din           = r_din[g_q*W +: W];
      k_src_ready     = r_src_ready[g_q];
      k_dst_ready     = r_dst_ready[g_q];
      r_src_read[g_q]  = k_src_read;
      r_dst_write[g_q] = k_dst_write;
    end
  end

  assign r_dout = {N_REQ{k_dout}};

endmodule
